// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit, one bit per cycle, with pipeline stall.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t              state;
    logic [2:0]          f3;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                neg_a, neg_b;
    logic [2*XLEN-1:0]   acc;
    logic [CW-1:0]       count;
    logic                sgn_a, sgn_b, in_neg_a, in_neg_b, is_div, b_zero, ovf;
    logic [XLEN-1:0]     ma, mb, special_res;
    logic [XLEN:0]       mul_sum, div_top;
    logic [XLEN-1:0]     div_diff, quo_r, rem_r, calc_res;
    logic                div_ge;
    logic [2*XLEN-1:0]   acc_next, prod;
    always_comb begin
        sgn_a       = ~(funct3 == 3'b011 | (funct3[2] & funct3[0]));
        sgn_b       = sgn_a & (funct3 != 3'b010);
        in_neg_a    = sgn_a & op_a[XLEN-1];
        in_neg_b    = sgn_b & op_b[XLEN-1];
        ma          = in_neg_a ? -op_a : op_a;
        mb          = in_neg_b ? -op_b : op_b;
        is_div      = funct3[2];
        b_zero      = is_div & (op_b == '0);
        ovf         = is_div & ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
        special_res = funct3[1] ? (b_zero ? op_a : '0) : (b_zero ? '1 : op_a);
        // multiply: {partial high, remaining multiplier}; divide: {partial remainder, dividend/quotient}
        mul_sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
        div_top     = acc[2*XLEN-1:XLEN-1];
        div_ge      = div_top >= {1'b0, mag_b};
        div_diff    = div_top[XLEN-1:0] - mag_b;
        acc_next    = f3[2] ? (div_ge ? {div_diff, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0})
                            : {mul_sum, acc[XLEN-1:1]};
        prod        = (neg_a ^ neg_b) ? -acc_next : acc_next;
        quo_r       = (neg_a ^ neg_b) ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem_r       = neg_a ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        calc_res    = f3[2] ? (f3[1] ? rem_r : quo_r)
                            : (f3 == 3'b000 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
        stall       = (state == CALC) | (state == IDLE & start & ~flush);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: if (start & ~flush) begin
                    f3    <= funct3;
                    mag_a <= ma;
                    mag_b <= mb;
                    neg_a <= in_neg_a;
                    neg_b <= in_neg_b;
                    acc   <= {{XLEN{1'b0}}, is_div ? ma : mb};
                    count <= '0;
                    busy  <= 1'b1;
                    if (b_zero | ovf) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= special_res;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: if (flush) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (count == CW'(XLEN-1)) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= calc_res;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random checks of muldiv_sequencer against an arithmetic model.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        stall, busy, done;
    logic [31:0] result;
    int          checks = 0;
    int          errors = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned pu;
        int              q, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        pu = {32'b0, a} * {32'b0, b};
        if (f == 3'd0) begin p = sa * sb; return p[31:0]; end
        if (f == 3'd1) begin p = sa * sb; return p[63:32]; end
        if (f == 3'd2) begin p = sa * longint'({32'b0, b}); return p[63:32]; end
        if (f == 3'd3) return pu[63:32];
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : a;
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return f[1] ? r : q;
        end
        return f[1] ? a % b : a / b;
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit hold);
        int n, stalls, lat;
        bit got, busy_ok;
        lat = (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        #1 chk("stall_accept", stall, 1);
        n = 0; stalls = 1; got = 0; busy_ok = 1;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (!busy) busy_ok = 0;
            if (done) got = 1;
            else if (stall) stalls++;
            start = hold;
            funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
        end
        chk("done_seen", got, 1);
        chk("latency", n, lat);
        chk("stall_cycles", stalls, lat);
        chk("busy_during_op", busy_ok, 1);
        chk("result", result, exp);
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
        chk("result_hold", result, exp);
    endtask

    task automatic quiet(input string tag);
        int d = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) d++;
        end
        chk(tag, d, 0);
    endtask

    initial begin
        logic [31:0] edges [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
        logic [2:0]  f;
        logic [31:0] a, b;
        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        chk("reset_stall", stall, 0);
        reset = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 0);
        run_op(3'd7, 32'd100, 32'd7, 32'd2, 0);
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'd5, 32'd0, 32'd5, 0);
        run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

        // flush while the counter reads 10
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy_before_flush", busy, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_done", done, 0);
        chk("flush_result", result, 0);
        quiet("flush_no_done");
        run_op(3'd5, 32'd1000, 32'd10, 32'd100, 0);

        // start and flush together in IDLE
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9;
        #1 chk("start_flush_stall", stall, 0);
        @(negedge clk);
        chk("start_flush_busy", busy, 0);
        start = 1'b0; flush = 1'b0;
        quiet("start_flush_no_done");

        // reset while the counter reads 20
        @(negedge clk);
        start = 1'b1; funct3 = 3'd3; op_a = 32'd11; op_b = 32'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        chk("midreset_result", result, 0);
        chk("midreset_stall", stall, 0);
        reset = 1'b0;
        quiet("midreset_no_done");

        // start held high through CALC and DONE must not retrigger
        run_op(3'd0, 32'd123, 32'd456, 32'd56088, 1);
        quiet("held_start_no_second_done");
        run_op(3'd7, 32'd5, 32'd0, 32'd5, 1);
        quiet("held_start_special_no_second_done");

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            if (f[2] && $urandom_range(0, 7) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            run_op(f, a, b, ref_model(f, a, b), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
